subband_serializer: RTL and testbench

SUBBAND_SERIALIZER -- requirements
Module: subband_serializer

---
 rtl/subband_serializer.sv | 191 +++++++++++++++++++
 tb/tb_subband_serializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/subband_serializer.sv
// subband_serializer
//   Takes a complete 16-subband analysis frame on a one-cycle strobe and
//   streams it out one rounded sample per transfer over a valid/ready port.
//   Two frame banks (active = draining, shadow = pending) absorb one frame
//   of backlog; a frame arriving while both banks are busy is dropped and
//   counted. Frames chain back to back with no idle cycle between them.
//
//   Optional feature macro: SUBBAND_SERIALIZER_SAT_EN
//     defined   -> out-of-range rounded samples clamp to max / min
//     undefined -> out-of-range rounded samples wrap (two's complement)
//
// Ports
//   clock        sole clock, rising edge
//   reset        synchronous, active-high
//   clk_enable   qualifies frame_valid (draining is unaffected)
//   frame_valid  one-cycle strobe: filter_in holds a full frame
//   filter_in    16 x 35-bit signed subband samples, 32 fractional bits
//   out_valid    out_data / out_chan / out_last are valid
//   out_ready    consumer accepts the current sample
//   out_data     rounded sample, OUT_W bits signed
//   out_chan     subband index of out_data (0..15)
//   out_last     marks subband 15
//   overrun      one-cycle pulse when a frame is dropped
//   drop_count   saturating count of dropped frames
module subband_serializer #(
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     frame_valid,
  input  logic signed [34:0]       filter_in [15:0],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [3:0]               out_chan,
  output logic                     out_last,
  output logic                     overrun,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int unsigned IN_W  = 35;
  localparam int unsigned EXT_W = 36;
  localparam int unsigned SHIFT = IN_W - OUT_W;

  // Half of one output LSB in input units; zero when no bits are discarded.
  localparam logic signed [EXT_W-1:0] RND = EXT_W'((37'd1 << SHIFT) >> 1);

`ifdef SUBBAND_SERIALIZER_SAT_EN
  localparam logic signed [EXT_W-1:0] MAXV = EXT_W'((37'd1 << (OUT_W - 1)) - 37'd1);
  localparam logic signed [EXT_W-1:0] MINV = -MAXV - 36'sd1;
`endif

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]              state;
  logic [0:0]              state_d;

  logic signed [IN_W-1:0]  active_bank [15:0];
  logic signed [IN_W-1:0]  shadow_bank [15:0];
  logic                    shadow_full;

  logic                    accept;
  logic                    xfer;
  logic                    last_xfer;

  logic                    take_new;
  logic                    take_shadow;
  logic                    fill_shadow;
  logic                    full_d;
  logic                    valid_d;
  logic [3:0]              chan_d;
  logic                    last_d;
  logic                    overrun_d;
  logic [DROP_W-1:0]       drop_d;
  logic signed [IN_W-1:0]  sel_sample;
  logic signed [OUT_W-1:0] data_d;

  // Round half-up in 36-bit signed, then clamp or wrap to OUT_W.
  function automatic logic signed [OUT_W-1:0] round_sample(input logic signed [IN_W-1:0] x);
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shr;
    sum = EXT_W'(x) + RND;
    shr = sum >>> SHIFT;
`ifdef SUBBAND_SERIALIZER_SAT_EN
    if (shr > MAXV)      shr = MAXV;
    else if (shr < MINV) shr = MINV;
`endif
    return OUT_W'(shr);
  endfunction

  assign accept    = frame_valid && clk_enable;
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (out_chan == 4'd15);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state, bank moves and next output values.
  always_comb begin
    state_d     = state;
    take_new    = 1'b0;
    take_shadow = 1'b0;
    fill_shadow = 1'b0;
    full_d      = shadow_full;
    valid_d     = out_valid;
    chan_d      = out_chan;
    overrun_d   = 1'b0;
    drop_d      = drop_count;

    case (state)
      S_IDLE: begin
        if (accept) begin
          take_new = 1'b1;
          valid_d  = 1'b1;
          chan_d   = 4'd0;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (xfer && !last_xfer) chan_d = out_chan + 4'd1;
        if (last_xfer) begin
          // Frame boundary: a pending or arriving frame follows with no bubble.
          chan_d = 4'd0;
          if (shadow_full) begin
            take_shadow = 1'b1;
            fill_shadow = accept;
            full_d      = accept;
          end else if (accept) begin
            take_new = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end else if (accept) begin
          if (!shadow_full) begin
            fill_shadow = 1'b1;
            full_d      = 1'b1;
          end else begin
            overrun_d = 1'b1;
            if (drop_count != '1) drop_d = drop_count + DROP_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    last_d = valid_d && (chan_d == 4'd15);

    // Sample the bank that will be active next cycle at the next channel.
    if (take_new)         sel_sample = filter_in[0];
    else if (take_shadow) sel_sample = shadow_bank[0];
    else                  sel_sample = active_bank[chan_d];

    data_d = valid_d ? round_sample(sel_sample) : out_data;
  end

  // Output and control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_chan    <= 4'd0;
      out_last    <= 1'b0;
      out_data    <= '0;
      overrun     <= 1'b0;
      drop_count  <= '0;
      shadow_full <= 1'b0;
    end else begin
      out_valid   <= valid_d;
      out_chan    <= chan_d;
      out_last    <= last_d;
      out_data    <= data_d;
      overrun     <= overrun_d;
      drop_count  <= drop_d;
      shadow_full <= full_d;
    end
  end

  // Frame banks carry no reset; contents are only read while marked valid.
  always_ff @(posedge clock) begin
    if (take_new)         active_bank <= filter_in;
    else if (take_shadow) active_bank <= shadow_bank;
    if (fill_shadow)      shadow_bank <= filter_in;
  end

endmodule

// File: tb/tb_subband_serializer.sv
// Bench for subband_serializer: directed scenarios plus random traffic,
// checked cycle by cycle against a frame-queue reference model.
module tb_subband_serializer;

  localparam int unsigned OUT_W  = 16;
  localparam int unsigned DROP_W = 8;
  localparam int          SH     = 35 - OUT_W;
  localparam int          DROP_MAX = (1 << DROP_W) - 1;

  typedef logic signed [34:0] frame_t [15:0];

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    clk_enable;
  logic                    frame_valid;
  logic signed [34:0]      filter_in [15:0];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [3:0]              out_chan;
  logic                    out_last;
  logic                    overrun;
  logic [DROP_W-1:0]       drop_count;

  subband_serializer #(.OUT_W(OUT_W), .DROP_W(DROP_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .frame_valid (frame_valid),
    .filter_in   (filter_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .out_last    (out_last),
    .overrun     (overrun),
    .drop_count  (drop_count)
  );

  always #5 clock = ~clock;

  // Reference model: queue of frames awaiting output (head is draining).
  frame_t q[$];
  frame_t cur;
  int     idx;
  logic   m_ovr;
  int     m_drops;
  logic   m_fresh;
  logic   armed;

  int n_vec;
  int n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Round half-up by floor((x + half LSB) / 2^SH), then clamp or wrap.
  function automatic logic [OUT_W-1:0] model_round(input logic signed [34:0] x);
    longint v;
    longint r;
    v = longint'(x);
    r = (v + ((longint'(1) <<< SH) >>> 1)) >>> SH;
`ifdef SUBBAND_SERIALIZER_SAT_EN
    if (r > (longint'(1) <<< (OUT_W - 1)) - 1) r = (longint'(1) <<< (OUT_W - 1)) - 1;
    if (r < -(longint'(1) <<< (OUT_W - 1)))    r = -(longint'(1) <<< (OUT_W - 1));
`endif
    return r[OUT_W-1:0];
  endfunction

  task automatic compare_outputs();
    logic busy;
    frame_t head;
    busy = (q.size() > 0);
    check("out_valid", 64'(out_valid), 64'(busy));
    check("out_chan",  64'(out_chan),  64'(idx));
    check("out_last",  64'(out_last),  64'(busy && idx == 15));
    if (busy) begin
      head = q[0];
      check("out_data", 64'($unsigned(out_data)), 64'(model_round(head[idx])));
    end else if (m_fresh) begin
      check("out_data_rst", 64'($unsigned(out_data)), 64'(0));
    end
    check("overrun",    64'(overrun),    64'(m_ovr));
    check("drop_count", 64'(drop_count), 64'(m_drops));
  endtask

  // One clock: check outputs, drive inputs, advance the model across the edge.
  task automatic step(input logic fv, input logic en, input logic rdy, input logic rst);
    @(negedge clock);
    if (armed) compare_outputs();
    frame_valid = fv;
    clk_enable  = en;
    out_ready   = rdy;
    reset       = rst;
    for (int k = 0; k < 16; k++) filter_in[k] = cur[k];
    if (rst) begin
      q.delete();
      idx     = 0;
      m_ovr   = 1'b0;
      m_drops = 0;
      m_fresh = 1'b1;
      armed   = 1'b1;
    end else begin
      m_ovr = 1'b0;
      if (q.size() > 0 && rdy) begin
        idx++;
        if (idx == 16) begin
          idx = 0;
          void'(q.pop_front());
        end
      end
      if (fv && en) begin
        if (q.size() < 2) begin
          q.push_back(cur);
          m_fresh = 1'b0;
        end else begin
          m_ovr = 1'b1;
          if (m_drops < DROP_MAX) m_drops++;
        end
      end
    end
  endtask

  // kind 0: ramp k<<19 (+ offset), 1: random, 2: rounding/range corner values
  task automatic new_frame(input int kind, input int offset);
    logic signed [34:0] sp [6];
    sp[0] = 35'h3_FFFF_FFFF;
    sp[1] = 35'h0_0004_0000;
    sp[2] = 35'h7_FFFC_0000;
    sp[3] = 35'h4_0000_0000;
    sp[4] = 35'h0_0003_FFFF;
    sp[5] = 35'h3_FFFB_FFFF;
    for (int k = 0; k < 16; k++) begin
      case (kind)
        0:       cur[k] = 35'(k + offset) <<< 19;
        1:       cur[k] = 35'({$urandom, $urandom});
        default: cur[k] = (k < 6) ? sp[k] : 35'({$urandom, $urandom});
      endcase
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    armed = 1'b0;
    idx = 0; m_ovr = 1'b0; m_drops = 0; m_fresh = 1'b1;
    reset = 1'b1; clk_enable = 1'b0; frame_valid = 1'b0; out_ready = 1'b0;
    new_frame(0, 0);

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    // Single ramp frame, consumer always ready.
    new_frame(0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0);

    // Ready toggling every cycle.
    new_frame(0, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'((i % 2) == 0), 1'b0);

    // Three frames two cycles apart while stalled: third is dropped.
    new_frame(1, 0); step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
    new_frame(1, 0); step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
    new_frame(1, 0); step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5)  step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b1, 1'b0);

    // Rounding and range corner values.
    new_frame(2, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0);

    // frame_valid with clk_enable low is ignored.
    new_frame(1, 0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);

    // Reset at chan 7 with a shadow frame pending, strobe during reset ignored.
    new_frame(1, 0); step(1'b1, 1'b1, 1'b1, 1'b0);
    new_frame(1, 0); step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && idx != 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    new_frame(0, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      new_frame(($urandom % 4 == 0) ? 2 : 1, 0);
      step(1'(($urandom % 3) == 0), 1'(($urandom % 4) != 0),
           1'(($urandom % 3) != 0), 1'(($urandom % 250) == 0));
    end

    // drop_count saturation.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DROP_MAX + 40; i++) begin
      new_frame(1, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    repeat (40) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
